// File: rtl/bocks_vga_timing.sv
// Video timing generator: sync, blanking, data enable and pixel coordinates.
// Define BOCKS_TIMING_CE_EN to add the ce_pix pixel clock enable port.
module bocks_vga_timing #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic        pclk,
   input  logic        reset,
`ifdef BOCKS_TIMING_CE_EN
   input  logic        ce_pix,
`endif
   output logic        hs,
   output logic        vs,
   output logic        de,
   output logic        hblank,
   output logic        vblank,
   output logic [11:0] x,
   output logic [11:0] y,
   output logic        line_start,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 4096 || V_TOTAL > 4096 ||
       H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
   begin : g_bad_cfg
      $error("bocks_vga_timing: zero parameter or total above 4096");
   end

   localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

   logic [11:0] hcnt;
   logic [11:0] vcnt;
   logic        step;
   logic        h_end;
   logic        v_end;
   logic        in_hs;
   logic        in_vs;

`ifdef BOCKS_TIMING_CE_EN
   assign step = ce_pix;
`else
   assign step = 1'b1;
`endif

   assign h_end = (hcnt == H_LAST);
   assign v_end = (vcnt == V_LAST);
   assign in_hs = (hcnt >= HS_BEG) && (hcnt < HS_END);
   assign in_vs = (vcnt >= VS_BEG) && (vcnt < VS_END);

   // Outputs decode the pre-increment counters, so all share one cycle of latency.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         hcnt        <= '0;
         vcnt        <= '0;
         x           <= '0;
         y           <= '0;
         hs          <= ~HS_POL;
         vs          <= ~VS_POL;
         de          <= 1'b0;
         hblank      <= 1'b0;
         vblank      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (step) begin
         hcnt        <= h_end ? 12'd0 : hcnt + 12'd1;
         if (h_end) begin
            vcnt <= v_end ? 12'd0 : vcnt + 12'd1;
         end
         x           <= hcnt;
         y           <= vcnt;
         hs          <= in_hs ? HS_POL : ~HS_POL;
         vs          <= in_vs ? VS_POL : ~VS_POL;
         hblank      <= (hcnt >= H_ACT);
         vblank      <= (vcnt >= V_ACT);
         de          <= (hcnt < H_ACT) && (vcnt < V_ACT);
         line_start  <= (hcnt == 12'd0);
         frame_start <= (hcnt == 12'd0) && (vcnt == 12'd0);
      end
   end

endmodule

// File: tb/tb_bocks_vga_timing.sv
// Bench for bocks_vga_timing: default and small-timing instances checked
// against an arithmetic model of position versus enabled cycles since reset.
module tb_bocks_vga_timing;

   logic pclk = 1'b0;
   logic reset = 1'b1;
   logic ce = 1'b1;

   always #5 pclk = ~pclk;

   logic hs_d, vs_d, de_d, hb_d, vb_d, ls_d, fs_d;
   logic [11:0] x_d, y_d;
   logic hs_s, vs_s, de_s, hb_s, vb_s, ls_s, fs_s;
   logic [11:0] x_s, y_s;

   bocks_vga_timing u_def (
      .pclk(pclk), .reset(reset),
`ifdef BOCKS_TIMING_CE_EN
      .ce_pix(ce),
`endif
      .hs(hs_d), .vs(vs_d), .de(de_d), .hblank(hb_d), .vblank(vb_d),
      .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d)
   );

   bocks_vga_timing #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1)
   ) u_sml (
      .pclk(pclk), .reset(reset),
`ifdef BOCKS_TIMING_CE_EN
      .ce_pix(ce),
`endif
      .hs(hs_s), .vs(vs_s), .de(de_s), .hblank(hb_s), .vblank(vb_s),
      .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
   );

   logic [30:0] obs_d, obs_s;
   assign obs_d = {hs_d, vs_d, de_d, hb_d, vb_d, ls_d, fs_d, x_d, y_d};
   assign obs_s = {hs_s, vs_s, de_s, hb_s, vb_s, ls_s, fs_s, x_s, y_s};

   int total = 0;
   int passed = 0;
   int k = 0;
   bit stat_on = 1'b0;
   int def_de = 0, def_hsl = 0;
   int sml_de = 0, sml_hsh = 0, sml_vsl = 0, sml_fs = 0;

   // Position after n enabled cycles: plain division of n by line/frame size.
   function automatic logic [30:0] model(
      int ha, int hf, int hsw, int hbp,
      int va, int vf, int vsw, int vbp,
      bit hp, bit vp, int n);
      int ht, vt, xx, yy;
      logic h, v, d, hbl, vbl, ls, fs;
      ht  = ha + hf + hsw + hbp;
      vt  = va + vf + vsw + vbp;
      xx  = n % ht;
      yy  = (n / ht) % vt;
      h   = (xx >= ha + hf && xx < ha + hf + hsw) ? hp : ~hp;
      v   = (yy >= va + vf && yy < va + vf + vsw) ? vp : ~vp;
      hbl = (xx >= ha);
      vbl = (yy >= va);
      d   = !hbl && !vbl;
      ls  = (xx == 0);
      fs  = (xx == 0) && (yy == 0);
      return {h, v, d, hbl, vbl, ls, fs, 12'(xx), 12'(yy)};
   endfunction

   function automatic logic [30:0] rst_vec(bit hp, bit vp);
      return {~hp, ~vp, 29'b0};
   endfunction

   function automatic logic [30:0] exp_def(int kk);
      if (kk == 0) return rst_vec(1'b0, 1'b0);
      return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, kk - 1);
   endfunction

   function automatic logic [30:0] exp_sml(int kk);
      if (kk == 0) return rst_vec(1'b1, 1'b0);
      return model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0, kk - 1);
   endfunction

   task automatic chk(input string tag, input logic [30:0] got,
                      input logic [30:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
   endtask

   task automatic step();
      int n;
      logic en;
`ifdef BOCKS_TIMING_CE_EN
      ce = 1'($urandom % 2);
`else
      ce = 1'b1;
`endif
      @(posedge pclk);
      en = !reset && ce;
      if (en) k++;
      @(negedge pclk);
      chk("def", obs_d, exp_def(k));
      chk("sml", obs_s, exp_sml(k));
      if (stat_on && en) begin
         n = k - 1;
         if (n < 800) begin
            def_de  += int'(de_d);
            def_hsl += int'(!hs_d);
         end
         if (n >= 48 && n < 96) begin
            sml_de  += int'(de_s);
            sml_hsh += int'(hs_s);
            sml_vsl += int'(!vs_s);
            sml_fs  += int'(fs_s);
         end
      end
   endtask

   initial begin
      int guard;
      reset = 1'b1;
      @(negedge pclk);
      repeat (10) step();
      reset = 1'b0;
      stat_on = 1'b1;
      repeat (1700 + $urandom_range(0, 100)) step();
      stat_on = 1'b0;

      chk("def_de_line", 31'(def_de), 31'd640);
      chk("def_hs_low_line", 31'(def_hsl), 31'd96);
      chk("sml_de_frame", 31'(sml_de), 31'd12);
      chk("sml_hs_high_frame", 31'(sml_hsh), 31'd12);
      chk("sml_vs_low_frame", 31'(sml_vsl), 31'd8);
      chk("sml_fs_frame", 31'(sml_fs), 31'd1);

      guard = 0;
      while (((k - 1) % 800) != 700 && guard < 3000) begin
         step();
         guard++;
      end
      chk("pre_rst_x", {19'b0, x_d}, 31'd700);

      #2 reset = 1'b1;
      #1;
      chk("async_rst_def", obs_d, rst_vec(1'b0, 1'b0));
      chk("async_rst_sml", obs_s, rst_vec(1'b1, 1'b0));
      k = 0;
      @(negedge pclk);
      repeat ($urandom_range(1, 5)) step();
      reset = 1'b0;
      repeat (300 + $urandom_range(0, 200)) step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
